// File: rtl/dma_wr_pkt_ctrl.sv
// Memory-write packet scheduler feeding the PCIe TX DMA engine from an FWFT FIFO into a host ring.
// Optional macro DMA_WR_HALF_IRQ_EN adds half_pulse, raised when the ring offset crosses the half-way mark.
module dma_wr_pkt_ctrl #(
    parameter int FIFO_CNT_W = 11,
    parameter int OFS_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dma_en,
    input  logic                  cfg_bus_mstr_enable_i,
    input  logic [31:0]           dma_base_addr,
    input  logic [OFS_W-1:0]      dma_buf_size,
    input  logic [5:0]            payload_dw,
    input  logic [31:0]           fifo_dout,
    input  logic [FIFO_CNT_W-1:0] fifo_count,
    output logic                  fifo_rd_en,
    input  logic                  tx_sof_n,
    input  logic                  tx_dsc_n,
    input  logic                  tx_data_ack,
    input  logic                  compl_done,
    output logic                  start_wr,
    output logic [31:0]           addr_o,
    output logic [31:0]           data_o,
    output logic [5:0]            data_payload,
    output logic                  wrap_pulse,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           dsc_cnt,
`ifdef DMA_WR_HALF_IRQ_EN
    output logic                  half_pulse,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, ARM, REQ, SEND, FLUSH, GAP} state_t;

    state_t           state, state_nxt;
    logic [5:0]       pl_cand;
    logic [5:0]       beat_cnt;
    logic [OFS_W-1:0] offset;
    logic [OFS_W:0]   pl_bytes;
    logic [OFS_W:0]   ofs_nxt;
    logic             wrap_hit;
    logic             advance;
    logic [31:0]      base_aligned;
    logic             unused_base_lsb;

    function automatic logic [5:0] clamp_payload(input logic [5:0] dw);
        if (dw == 6'd0)
            return 6'd1;
        else if (dw > 6'd32)
            return 6'd32;
        else
            return dw;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pl_cand         = clamp_payload(payload_dw);
    assign base_aligned    = {dma_base_addr[31:2], 2'b00};
    assign unused_base_lsb = ^dma_base_addr[1:0];
    assign data_o          = fifo_dout;
    assign busy            = (state != IDLE);

    // One extra bit so offset + payload never aliases past a ring near 2^OFS_W.
    assign pl_bytes = {{(OFS_W-7){1'b0}}, data_payload, 2'b00};
    assign ofs_nxt  = {1'b0, offset} + pl_bytes;
    assign wrap_hit = (ofs_nxt >= {1'b0, dma_buf_size});
    assign advance  = (state == SEND) && (!tx_dsc_n || compl_done);

`ifdef DMA_WR_HALF_IRQ_EN
    logic [OFS_W:0] half_thr;
    logic           half_hit;
    assign half_thr = {1'b0, dma_buf_size} >> 1;
    assign half_hit = !wrap_hit && ({1'b0, offset} < half_thr) && (ofs_nxt >= half_thr);
`endif

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (dma_en && cfg_bus_mstr_enable_i)
                    state_nxt = ARM;
            end
            ARM: begin
                if (!dma_en)
                    state_nxt = IDLE;
                else if (fifo_count >= FIFO_CNT_W'(pl_cand))
                    state_nxt = REQ;
            end
            REQ: begin
                fifo_rd_en = tx_data_ack;
                if (!tx_sof_n)
                    state_nxt = SEND;
            end
            SEND: begin
                fifo_rd_en = tx_data_ack;
                if (!tx_dsc_n)
                    state_nxt = FLUSH;
                else if (compl_done)
                    state_nxt = GAP;
            end
            FLUSH: begin
                // Discard the unsent remainder so the next packet starts on a packet boundary.
                fifo_rd_en = (beat_cnt < data_payload);
                if (({1'b0, beat_cnt} + 7'd1) >= {1'b0, data_payload})
                    state_nxt = GAP;
            end
            GAP: begin
                state_nxt = (dma_en && cfg_bus_mstr_enable_i) ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_wr     <= 1'b0;
            addr_o       <= base_aligned;
            data_payload <= 6'd0;
            wrap_pulse   <= 1'b0;
            pkt_cnt      <= 32'd0;
            dsc_cnt      <= 16'd0;
            offset       <= '0;
            beat_cnt     <= 6'd0;
`ifdef DMA_WR_HALF_IRQ_EN
            half_pulse   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            wrap_pulse <= 1'b0;
`ifdef DMA_WR_HALF_IRQ_EN
            half_pulse <= 1'b0;
`endif
            if (state == ARM && state_nxt == REQ) begin
                start_wr     <= 1'b1;
                data_payload <= pl_cand;
                addr_o       <= base_aligned + 32'(offset);
                beat_cnt     <= 6'd0;
            end else if (fifo_rd_en) begin
                beat_cnt <= beat_cnt + 6'd1;
            end

            if (state == REQ && !tx_sof_n)
                start_wr <= 1'b0;

            if (advance) begin
                if (!tx_dsc_n)
                    dsc_cnt <= sat_inc16(dsc_cnt);
                else
                    pkt_cnt <= pkt_cnt + 32'd1;
                if (wrap_hit) begin
                    offset     <= '0;
                    wrap_pulse <= 1'b1;
                end else begin
                    offset <= ofs_nxt[OFS_W-1:0];
                end
`ifdef DMA_WR_HALF_IRQ_EN
                half_pulse <= half_hit;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dma_wr_pkt_ctrl.sv
// Self-checking bench for dma_wr_pkt_ctrl: per-cycle vector table plus directed packet sequences.
// Define DMA_WR_HALF_IRQ_EN on both files to also check half_pulse.
module tb_dma_wr_pkt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_en;
    logic        cfg_bus_mstr_enable_i;
    logic [31:0] dma_base_addr;
    logic [23:0] dma_buf_size;
    logic [5:0]  payload_dw;
    logic [31:0] fifo_dout;
    logic [10:0] fifo_count;
    logic        fifo_rd_en;
    logic        tx_sof_n;
    logic        tx_dsc_n;
    logic        tx_data_ack;
    logic        compl_done;
    logic        start_wr;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [5:0]  data_payload;
    logic        wrap_pulse;
    logic [31:0] pkt_cnt;
    logic [15:0] dsc_cnt;
    logic        busy;
`ifdef DMA_WR_HALF_IRQ_EN
    logic        half_pulse;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_wr_pkt_ctrl #(.FIFO_CNT_W(11), .OFS_W(24)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .dma_en                (dma_en),
        .cfg_bus_mstr_enable_i (cfg_bus_mstr_enable_i),
        .dma_base_addr         (dma_base_addr),
        .dma_buf_size          (dma_buf_size),
        .payload_dw            (payload_dw),
        .fifo_dout             (fifo_dout),
        .fifo_count            (fifo_count),
        .fifo_rd_en            (fifo_rd_en),
        .tx_sof_n              (tx_sof_n),
        .tx_dsc_n              (tx_dsc_n),
        .tx_data_ack           (tx_data_ack),
        .compl_done            (compl_done),
        .start_wr              (start_wr),
        .addr_o                (addr_o),
        .data_o                (data_o),
        .data_payload          (data_payload),
        .wrap_pulse            (wrap_pulse),
        .pkt_cnt               (pkt_cnt),
        .dsc_cnt               (dsc_cnt),
`ifdef DMA_WR_HALF_IRQ_EN
        .half_pulse            (half_pulse),
`endif
        .busy                  (busy)
    );

    typedef struct {
        logic        en;
        logic [10:0] cnt;
        logic        sof_n;
        logic        dsc_n;
        logic        ack;
        logic        done;
        logic        exp_start;
        logic        exp_rd;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        dma_en      = 1'b0;
        tx_sof_n    = 1'b1;
        tx_dsc_n    = 1'b1;
        tx_data_ack = 1'b0;
        compl_done  = 1'b0;
        fifo_count  = 11'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Runs one packet through the DUT, acting as the TX engine.
    task automatic send_pkt(input string nm, input int beats, input bit dsc,
                            input logic [31:0] exp_addr, input logic [5:0] exp_pl,
                            input bit exp_wrap, input bit exp_half, input int exp_pops);
        int n;
        int pops;
        bit got;
        dma_en     = 1'b1;
        fifo_count = 11'd64;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_wr) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s start_wr timeout actual=0 expected=1", nm);
        end
        dma_en = 1'b0;
        chk({nm, " addr"}, addr_o, exp_addr);
        chk({nm, " payload"}, {26'd0, data_payload}, {26'd0, exp_pl});
        tx_sof_n = 1'b0;
        tick();
        tx_sof_n = 1'b1;
        chk({nm, " start drop"}, {31'd0, start_wr}, 32'd0);
        n = 0;
        while (n < beats) begin
            tx_data_ack = 1'b1;
            tick();
            n++;
        end
        tx_data_ack = 1'b0;
        if (dsc) tx_dsc_n = 1'b0;
        else     compl_done = 1'b1;
        tick();
        tx_dsc_n   = 1'b1;
        compl_done = 1'b0;
        chk({nm, " wrap"}, {31'd0, wrap_pulse}, {31'd0, exp_wrap});
`ifdef DMA_WR_HALF_IRQ_EN
        chk({nm, " half"}, {31'd0, half_pulse}, {31'd0, exp_half});
`else
        if (exp_half) n = 0;
`endif
        if (dsc) begin
            pops = 0;
            for (int i = 0; i < 10; i++) begin
                if (fifo_rd_en) pops++;
                tick();
            end
            chk({nm, " flush pops"}, pops, exp_pops);
        end
        tick();
        tick();
    endtask

    initial begin
        cfg_bus_mstr_enable_i = 1'b1;
        dma_base_addr = 32'h1000_0000;
        dma_buf_size  = 24'h000100;
        payload_dw    = 6'd8;
        fifo_dout     = 32'hA5A5_1234;

        //          en  cnt  sof dsc ack done  start rd busy
        tbl[0]  = '{1'b1, 11'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 11'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 11'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 11'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 11'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk("rst start_wr", {31'd0, start_wr}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst addr", addr_o, 32'h1000_0000);
        chk("rst payload", {26'd0, data_payload}, 32'd0);
        chk("rst wrap", {31'd0, wrap_pulse}, 32'd0);
        chk("rst pkt_cnt", pkt_cnt, 32'd0);
        chk("rst dsc_cnt", {16'd0, dsc_cnt}, 32'd0);
        chk("data_o", data_o, 32'hA5A5_1234);

        for (int i = 0; i < 13; i++) begin
            dma_en      = tbl[i].en;
            fifo_count  = tbl[i].cnt;
            tx_sof_n    = tbl[i].sof_n;
            tx_dsc_n    = tbl[i].dsc_n;
            tx_data_ack = tbl[i].ack;
            compl_done  = tbl[i].done;
            @(negedge clk);
            chk($sformatf("vec%0d start_wr", i), {31'd0, start_wr}, {31'd0, tbl[i].exp_start});
            chk($sformatf("vec%0d fifo_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].exp_rd});
            chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
            tick();
        end
        chk("vec pkt_cnt", pkt_cnt, 32'd1);
        chk("vec addr", addr_o, 32'h1000_0000);
        chk("vec payload", {26'd0, data_payload}, 32'd8);

        // Ring of 0x100 bytes with 64-byte packets: wraps after the fourth.
        do_reset();
        payload_dw = 6'd16;
        send_pkt("ring1", 16, 1'b0, 32'h1000_0000, 6'd16, 1'b0, 1'b0, 0);
        send_pkt("ring2", 16, 1'b0, 32'h1000_0040, 6'd16, 1'b0, 1'b1, 0);
        send_pkt("ring3", 16, 1'b0, 32'h1000_0080, 6'd16, 1'b0, 1'b0, 0);
        send_pkt("ring4", 16, 1'b0, 32'h1000_00C0, 6'd16, 1'b1, 1'b0, 0);
        send_pkt("ring5", 16, 1'b0, 32'h1000_0000, 6'd16, 1'b0, 1'b0, 0);
        chk("ring pkt_cnt", pkt_cnt, 32'd5);
        chk("ring dsc_cnt", {16'd0, dsc_cnt}, 32'd0);

        // Discontinue after 3 of 8 beats, then payload clamping.
        do_reset();
        payload_dw = 6'd8;
        send_pkt("dsc1", 3, 1'b1, 32'h1000_0000, 6'd8, 1'b0, 1'b0, 5);
        chk("dsc dsc_cnt", {16'd0, dsc_cnt}, 32'd1);
        chk("dsc pkt_cnt", pkt_cnt, 32'd0);
        send_pkt("dsc2", 8, 1'b0, 32'h1000_0020, 6'd8, 1'b0, 1'b0, 0);
        payload_dw = 6'd0;
        send_pkt("clamp0", 1, 1'b0, 32'h1000_0040, 6'd1, 1'b0, 1'b0, 0);
        payload_dw = 6'd40;
        send_pkt("clamp40", 32, 1'b0, 32'h1000_0044, 6'd32, 1'b0, 1'b1, 0);
        chk("end pkt_cnt", pkt_cnt, 32'd3);
        chk("end dsc_cnt", {16'd0, dsc_cnt}, 32'd1);
        chk("end busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
